// File: rtl/obstacle_gen.sv
// obstacle_gen: sweeps six vertical obstacle lanes (2..7) once per frame tick,
// bouncing each segment between V_TOP and V_BOT at a level-dependent speed.
// Optional build macro OBST_LFSR_EN: segment length is re-drawn from a 16-bit
// LFSR on every top bounce; without it lengths stay at LEN_FIXED.
module obstacle_gen #(
    parameter int unsigned V_TOP      = 0,
    parameter int unsigned V_BOT      = 480,
    parameter int unsigned LEN_FIXED  = 80,
    parameter int unsigned LEN_MIN    = 40,
    parameter int unsigned SPEED_BASE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       restart,
    input  logic [9:0] level,
    output logic [9:0] bar_pos2,
    output logic [9:0] bar_pos3,
    output logic [9:0] bar_pos4,
    output logic [9:0] bar_pos5,
    output logic [9:0] bar_pos6,
    output logic [9:0] bar_pos7,
    output logic [9:0] bar_op2,
    output logic [9:0] bar_op3,
    output logic [9:0] bar_op4,
    output logic [9:0] bar_op5,
    output logic [9:0] bar_op6,
    output logic [9:0] bar_op7,
    output logic       busy,
    output logic       sweep_done
);

    localparam int unsigned N_LANES    = 6;
    localparam int unsigned PW         = 10;
    localparam int unsigned AW         = 11;
    localparam int unsigned LANE_PITCH = 40;
    localparam int unsigned LVL_MAX    = 15;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      idx, idx_nxt;
    logic            busy_nxt, done_nxt;
    logic            lane_we;
    logic            spd_ld;
    logic [AW-1:0]   spd_q;
    logic [AW-1:0]   spd_new;
    logic [3:0]      lvl_sat;

    logic [PW-1:0]   pos_q [N_LANES];
    logic [PW-1:0]   op_q  [N_LANES];
    logic            dn_q  [N_LANES];

    logic [PW-1:0]   cur_pos, cur_op;
    logic            cur_dn;
    logic [AW-1:0]   sum_down;
    logic [PW-1:0]   new_pos, new_op;
    logic            new_dn;

`ifdef OBST_LFSR_EN
    logic [15:0]     lfsr_q;
`endif

    // Saturated speed for the sweep being launched
    always_comb begin
        lvl_sat = (level > 10'(LVL_MAX)) ? 4'(LVL_MAX) : level[3:0];
        spd_new = AW'(SPEED_BASE) + AW'(lvl_sat);
    end

    // Control state, lane index, speed latch and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            spd_q      <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            busy       <= busy_nxt;
            sweep_done <= done_nxt;
            if (spd_ld) spd_q <= spd_new;
        end
    end

    // Next-state logic: restart overrides everything, ticks ignored mid-sweep
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        lane_we   = 1'b0;
        spd_ld    = 1'b0;
        if (restart) begin
            state_nxt = IDLE;
            idx_nxt   = 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        state_nxt = SWEEP;
                        idx_nxt   = 3'd0;
                        busy_nxt  = 1'b1;
                        spd_ld    = 1'b1;
                    end
                end
                SWEEP: begin
                    lane_we = 1'b1;
                    if (idx == 3'(N_LANES - 1)) begin
                        state_nxt = IDLE;
                        idx_nxt   = 3'd0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt  = idx + 3'd1;
                        busy_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bounce/advance computation for the lane selected by idx
    always_comb begin
        cur_pos  = pos_q[idx];
        cur_op   = op_q[idx];
        cur_dn   = dn_q[idx];
        sum_down = AW'(cur_pos) + AW'(cur_op) + spd_q;
        new_pos  = cur_pos;
        new_op   = cur_op;
        new_dn   = cur_dn;
        if (cur_dn) begin
            if (sum_down >= AW'(V_BOT)) begin
                new_pos = PW'(AW'(V_BOT) - AW'(cur_op));
                new_dn  = 1'b0;
            end else begin
                new_pos = PW'(AW'(cur_pos) + spd_q);
            end
        end else begin
            if (AW'(cur_pos) <= AW'(V_TOP) + spd_q) begin
                new_pos = PW'(V_TOP);
                new_dn  = 1'b1;
`ifdef OBST_LFSR_EN
                new_op  = PW'(LEN_MIN) + PW'(lfsr_q[6:0]);
`endif
            end else begin
                new_pos = PW'(AW'(cur_pos) - spd_q);
            end
        end
    end

    // Lane storage: start layout on reset/restart, one lane written per sweep cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_LANES; i++) begin
                pos_q[i] <= PW'(LANE_PITCH * i);
                op_q[i]  <= PW'(LEN_FIXED);
                dn_q[i]  <= ((i % 2) == 0);
            end
        end else if (restart) begin
            for (int i = 0; i < N_LANES; i++) begin
                pos_q[i] <= PW'(LANE_PITCH * i);
                op_q[i]  <= PW'(LEN_FIXED);
                dn_q[i]  <= ((i % 2) == 0);
            end
        end else if (lane_we) begin
            pos_q[idx] <= new_pos;
            op_q[idx]  <= new_op;
            dn_q[idx]  <= new_dn;
        end
    end

`ifdef OBST_LFSR_EN
    // Fibonacci LFSR, taps 16,14,13,11; advances every sweep cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else if (lane_we) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`endif

    assign bar_pos2 = pos_q[0];
    assign bar_pos3 = pos_q[1];
    assign bar_pos4 = pos_q[2];
    assign bar_pos5 = pos_q[3];
    assign bar_pos6 = pos_q[4];
    assign bar_pos7 = pos_q[5];
    assign bar_op2  = op_q[0];
    assign bar_op3  = op_q[1];
    assign bar_op4  = op_q[2];
    assign bar_op5  = op_q[3];
    assign bar_op6  = op_q[4];
    assign bar_op7  = op_q[5];

endmodule

// File: tb/tb_obstacle_gen.sv
// Self-checking bench for obstacle_gen: a behavioural lane model pushes the
// expected per-lane results of each sweep into a queue when the tick is driven;
// entries are popped and compared as the DUT writes each lane.
module tb_obstacle_gen;

    localparam int V_TOP = 0;
    localparam int V_BOT = 480;
    localparam int LEN_FIXED = 80;
    localparam int LEN_MIN = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       restart = 1'b0;
    logic [9:0] level = 10'd0;
    logic [9:0] bar_pos2, bar_pos3, bar_pos4, bar_pos5, bar_pos6, bar_pos7;
    logic [9:0] bar_op2, bar_op3, bar_op4, bar_op5, bar_op6, bar_op7;
    logic       busy, sweep_done;

    obstacle_gen dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .restart(restart), .level(level),
        .bar_pos2(bar_pos2), .bar_pos3(bar_pos3), .bar_pos4(bar_pos4),
        .bar_pos5(bar_pos5), .bar_pos6(bar_pos6), .bar_pos7(bar_pos7),
        .bar_op2(bar_op2), .bar_op3(bar_op3), .bar_op4(bar_op4),
        .bar_op5(bar_op5), .bar_op6(bar_op6), .bar_op7(bar_op7),
        .busy(busy), .sweep_done(sweep_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lane;
        int pos;
        int op;
    } exp_t;

    exp_t        exp_q[$];
    int          m_pos [2:7];
    int          m_op  [2:7];
    bit          m_dn  [2:7];
    int          prev_pos [2:7];
    logic [15:0] m_lfsr;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic int dut_pos(input int lane);
        case (lane)
            2: return int'(bar_pos2);
            3: return int'(bar_pos3);
            4: return int'(bar_pos4);
            5: return int'(bar_pos5);
            6: return int'(bar_pos6);
            default: return int'(bar_pos7);
        endcase
    endfunction

    function automatic int dut_op(input int lane);
        case (lane)
            2: return int'(bar_op2);
            3: return int'(bar_op3);
            4: return int'(bar_op4);
            5: return int'(bar_op5);
            6: return int'(bar_op6);
            default: return int'(bar_op7);
        endcase
    endfunction

    function automatic void model_layout();
        for (int l = 2; l <= 7; l++) begin
            m_pos[l] = 40 * (l - 2);
            m_op[l]  = LEN_FIXED;
            m_dn[l]  = (l % 2 == 0);
        end
    endfunction

    // Advance the model by one full sweep, queueing each lane's expected result
    function automatic void model_sweep(input int spd);
        exp_t e;
        for (int l = 2; l <= 7; l++) prev_pos[l] = m_pos[l];
        for (int l = 2; l <= 7; l++) begin
            if (m_dn[l]) begin
                if (m_pos[l] + m_op[l] + spd >= V_BOT) begin
                    m_pos[l] = V_BOT - m_op[l];
                    m_dn[l]  = 1'b0;
                end else begin
                    m_pos[l] = m_pos[l] + spd;
                end
            end else if (m_pos[l] <= V_TOP + spd) begin
                m_pos[l] = V_TOP;
                m_dn[l]  = 1'b1;
`ifdef OBST_LFSR_EN
                m_op[l]  = LEN_MIN + int'(m_lfsr[6:0]);
`endif
            end else begin
                m_pos[l] = m_pos[l] - spd;
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            e.lane = l;
            e.pos  = m_pos[l];
            e.op   = m_op[l];
            exp_q.push_back(e);
        end
    endfunction

    function automatic int model_spd();
        return 1 + ((int'(level) > 15) ? 15 : int'(level));
    endfunction

    // One sweep; optionally pokes ticks (and a level change) mid-sweep, or chains the next tick at E7
    task automatic run_sweep(input bit ticks_in_sweep, input bit chain, input bit started);
        exp_t e;
        logic [9:0] saved_level;
        saved_level = level;
        if (!started) begin
            @(negedge clk);
            model_sweep(model_spd());
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            n_checks++;
            if (busy !== 1'b1 || sweep_done !== 1'b0) begin
                n_fail++;
                $display("FAIL e0_status busy=%b done=%b required busy=1 done=0", busy, sweep_done);
            end
        end
        for (int k = 2; k <= 7; k++) begin
            if (ticks_in_sweep) begin
                frame_tick = (k == 4 || k == 7);
                level = (k == 4) ? 10'd999 : saved_level;
            end
            @(posedge clk); #1;
            frame_tick = 1'b0;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty lane=%0d", k);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (dut_pos(e.lane) !== e.pos || dut_op(e.lane) !== e.op) begin
                    n_fail++;
                    $display("FAIL lane%0d_write pos=%0d op=%0d required pos=%0d op=%0d",
                             e.lane, dut_pos(e.lane), dut_op(e.lane), e.pos, e.op);
                end
            end
            if (k < 7) begin
                n_checks++;
                if (dut_pos(k + 1) !== prev_pos[k + 1]) begin
                    n_fail++;
                    $display("FAIL lane%0d_early pos=%0d required %0d", k + 1, dut_pos(k + 1), prev_pos[k + 1]);
                end
                n_checks++;
                if (busy !== 1'b1 || sweep_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sweep_status_e%0d busy=%b done=%b required busy=1 done=0", k - 1, busy, sweep_done);
                end
            end else begin
                n_checks++;
                if (busy !== 1'b0 || sweep_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL e6_status busy=%b done=%b required busy=0 done=1", busy, sweep_done);
                end
            end
        end
        level = saved_level;
        if (chain) begin
            model_sweep(model_spd());
            frame_tick = 1'b1;
        end
        @(posedge clk); #1;
        frame_tick = 1'b0;
        n_checks++;
        if (sweep_done !== 1'b0 || busy !== chain) begin
            n_fail++;
            $display("FAIL e7_status busy=%b done=%b required busy=%b done=0", busy, sweep_done, chain);
        end
    endtask

    // Pulse restart (optionally with a coincident tick) and check the layout
    task automatic apply_restart(input bit with_tick);
        @(negedge clk);
        restart = 1'b1;
        frame_tick = with_tick;
        @(posedge clk); #1;
        restart = 1'b0;
        frame_tick = 1'b0;
        model_layout();
        exp_q.delete();
        for (int l = 2; l <= 7; l++) begin
            n_checks++;
            if (dut_pos(l) !== 40 * (l - 2) || dut_op(l) !== LEN_FIXED) begin
                n_fail++;
                $display("FAIL restart_lane%0d pos=%0d op=%0d required pos=%0d op=%0d",
                         l, dut_pos(l), dut_op(l), 40 * (l - 2), LEN_FIXED);
            end
        end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (busy !== 1'b0 || sweep_done !== 1'b0) begin
                n_fail++;
                $display("FAIL restart_idle_c%0d busy=%b done=%b required busy=0 done=0", c, busy, sweep_done);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_layout();
        m_lfsr = 16'hACE1;
        @(posedge clk); #1;
        for (int l = 2; l <= 7; l++) begin
            n_checks++;
            if (dut_pos(l) !== 40 * (l - 2) || dut_op(l) !== LEN_FIXED) begin
                n_fail++;
                $display("FAIL reset_lane%0d pos=%0d op=%0d required pos=%0d op=%0d",
                         l, dut_pos(l), dut_op(l), 40 * (l - 2), LEN_FIXED);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status busy=%b done=%b required busy=0 done=0", busy, sweep_done);
        end
    endtask

    task automatic test_level0();
        level = 10'd0;
        run_sweep(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_pos(2) !== 1 || dut_pos(3) !== 39 || dut_pos(7) !== 199) begin
            n_fail++;
            $display("FAIL level0_positions p2=%0d p3=%0d p7=%0d required 1 39 199",
                     dut_pos(2), dut_pos(3), dut_pos(7));
        end
    endtask

    task automatic test_saturation();
        apply_restart(1'b0);
        level = 10'd100;
        run_sweep(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_pos(2) !== 16) begin
            n_fail++;
            $display("FAIL speed_saturation pos2=%0d required 16", dut_pos(2));
        end
    endtask

    task automatic test_down_bounce();
        apply_restart(1'b0);
        level = 10'd15;
        repeat (24) run_sweep(1'b0, 1'b0, 1'b0);
        level = 10'd10;
        run_sweep(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_pos(2) !== 395 || dut_op(2) !== 80) begin
            n_fail++;
            $display("FAIL down_setup pos2=%0d op2=%0d required 395 80", dut_pos(2), dut_op(2));
        end
        level = 10'd9;
        run_sweep(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_pos(2) !== 400) begin
            n_fail++;
            $display("FAIL down_bounce pos2=%0d required 400", dut_pos(2));
        end
        run_sweep(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_pos(2) !== 390) begin
            n_fail++;
            $display("FAIL down_reverse pos2=%0d required 390", dut_pos(2));
        end
    endtask

    task automatic test_up_bounce();
        apply_restart(1'b0);
        level = 10'd4;
        repeat (7) run_sweep(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_pos(3) !== 5) begin
            n_fail++;
            $display("FAIL up_setup pos3=%0d required 5", dut_pos(3));
        end
        level = 10'd9;
        run_sweep(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (dut_pos(3) !== 0) begin
            n_fail++;
            $display("FAIL up_bounce pos3=%0d required 0", dut_pos(3));
        end
`ifdef OBST_LFSR_EN
        n_checks++;
        if (dut_op(3) < LEN_MIN || dut_op(3) > LEN_MIN + 127) begin
            n_fail++;
            $display("FAIL up_bounce_len op3=%0d required 40..167", dut_op(3));
        end
`else
        n_checks++;
        if (dut_op(3) !== LEN_FIXED) begin
            n_fail++;
            $display("FAIL up_bounce_len op3=%0d required %0d", dut_op(3), LEN_FIXED);
        end
`endif
    endtask

    task automatic test_back_to_back();
        level = 10'd2;
        run_sweep(1'b1, 1'b1, 1'b0);
        run_sweep(1'b0, 1'b0, 1'b1);
    endtask

    // Restart sampled at E3 of a sweep (with a coincident tick), then restart+tick from idle
    task automatic test_restart_abort();
        exp_t e;
        level = 10'd3;
        @(negedge clk);
        model_sweep(model_spd());
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_checks++;
            if (dut_pos(e.lane) !== e.pos) begin
                n_fail++;
                $display("FAIL abort_lane%0d pos=%0d required %0d", e.lane, dut_pos(e.lane), e.pos);
            end
        end
        restart = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        frame_tick = 1'b0;
        model_layout();
        exp_q.delete();
        for (int l = 2; l <= 7; l++) begin
            n_checks++;
            if (dut_pos(l) !== 40 * (l - 2) || dut_op(l) !== LEN_FIXED) begin
                n_fail++;
                $display("FAIL abort_layout_lane%0d pos=%0d op=%0d required pos=%0d op=%0d",
                         l, dut_pos(l), dut_op(l), 40 * (l - 2), LEN_FIXED);
            end
        end
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (busy !== 1'b0 || sweep_done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_idle_c%0d busy=%b done=%b required busy=0 done=0", c, busy, sweep_done);
            end
            @(posedge clk); #1;
        end
        apply_restart(1'b1);
    endtask

    initial begin
        test_reset();
        test_level0();
        test_saturation();
        test_down_bounce();
        test_up_bounce();
        test_back_to_back();
        test_restart_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
